gate_selftest_seq: RTL

- Clocked truth-table sequencer that wraps any of the team's 2-input basic gates (nor_gate and siblings).
- Drives every input combination onto the gate, waits a settle window, then samples the gate output.
- Compares each sample against a parameterised expected truth table and accumulates pass/fail results.
- It is both the stimulus stage feeding the gate and the checker consuming its output, so the gates can be self-tested in hardware without a simulator testbench.

---
 rtl/gate_test_pkg.sv | 19 +
 rtl/gate_settle_timer.sv | 40 ++++
 rtl/gate_selftest_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and expected truth tables for the 2-input gate self-test sequencer.
package gate_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Bit k is the expected output for stimulus k, where stim[1]=A and stim[0]=B.
   localparam logic [3:0] EXP_NOR  = 4'b0001;
   localparam logic [3:0] EXP_OR   = 4'b1110;
   localparam logic [3:0] EXP_AND  = 4'b1000;
   localparam logic [3:0] EXP_NAND = 4'b0111;
   localparam logic [3:0] EXP_XOR  = 4'b0110;
   localparam logic [3:0] EXP_XNOR = 4'b1001;

endpackage

// File: rtl/gate_settle_timer.sv
// Settle window counter.
// Counts enabled cycles from a clear and flags the last cycle of the window.
module gate_settle_timer
   import gate_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_c = (cnt_q == LAST);

   // Saturates at LAST so a single-cycle window never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired_c) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_selftest_seq.sv
// Truth-table self-test sequencer: drives every input vector onto a gate,
// waits a settle window, samples the gate output and accumulates mismatches.
module gate_selftest_seq
   import gate_test_pkg::*;
#(
   parameter int unsigned               N_INPUTS      = 2,
   parameter int unsigned               SETTLE_CYCLES = 2,
   parameter logic [(2**N_INPUTS)-1:0]  EXP_TABLE     = EXP_NOR
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic [N_INPUTS-1:0]          stim,
   input  logic                         dut_out,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [N_INPUTS:0]            fail_count,
   output logic [(2**N_INPUTS)-1:0]     fail_mask
);

   localparam int unsigned V   = 2**N_INPUTS;
   localparam int unsigned FCW = N_INPUTS + 1;
   localparam logic [N_INPUTS-1:0] LAST_IDX = N_INPUTS'(V - 1);

   state_e              state_q, state_d;
   logic [N_INPUTS-1:0] stim_q, stim_d;
   logic [N_INPUTS-1:0] idx_q, idx_d;
   logic [FCW-1:0]      fcnt_q, fcnt_d;
   logic [V-1:0]        fmask_q, fmask_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;

   logic tmr_clear_c, tmr_en_c, tmr_expired_c;
   logic mismatch_c;

   gate_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (tmr_clear_c),
      .enable    (tmr_en_c),
      .expired_c (tmr_expired_c)
   );

   // Case inequality so an X or Z from the gate is scored as a failure.
   assign mismatch_c = (dut_out !== EXP_TABLE[idx_q]);

   always_comb begin
      state_d     = state_q;
      stim_d      = stim_q;
      idx_d       = idx_q;
      fcnt_d      = fcnt_q;
      fmask_d     = fmask_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      tmr_clear_c = 1'b0;
      tmr_en_c    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_DRIVE;
               stim_d      = '0;
               idx_d       = '0;
               fcnt_d      = '0;
               fmask_d     = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               tmr_clear_c = 1'b1;
            end
         end
         ST_DRIVE: begin
            tmr_en_c = 1'b1;
            if (tmr_expired_c) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            tmr_clear_c = 1'b1;
            if (mismatch_c) begin
               fmask_d[idx_q] = 1'b1;
               fcnt_d         = fcnt_q + FCW'(1);
            end
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (fcnt_d == '0);
            end else begin
               state_d = ST_DRIVE;
               idx_d   = idx_q + N_INPUTS'(1);
               stim_d  = idx_q + N_INPUTS'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         idx_q   <= '0;
         fcnt_q  <= '0;
         fmask_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         idx_q   <= idx_d;
         fcnt_q  <= fcnt_d;
         fmask_q <= fmask_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fcnt_q;
   assign fail_mask  = fmask_q;

endmodule
